// File: rtl/sprite_palette_ram.sv
`default_nettype none
// ============================================================================
// Module   : sprite_palette_ram
// Brief    : Double-banked sprite colour RAM. The pixel pipeline reads the
//            front bank with 2-cycle latency. Bus writes (per-channel masked)
//            and a whole-bank fill engine target the back bank. Banks swap
//            only on a frame_start tick, so sprite updates never tear.
// Options  : SPRITE_PALETTE_TRANSP_EN - when defined, a RAM word equal to
//            KEY_COLOR raises transp and forces dout to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_palette_ram #(
  parameter int                                DATA_WIDTH = 4,
  parameter int                                NUM_CH     = 3,
  parameter int                                ADDR_WIDTH = 10,
  parameter logic [NUM_CH*DATA_WIDTH-1:0]      KEY_COLOR  = '0
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  // pixel read port (front bank)
  input  logic                                 rd_en,
  input  logic [ADDR_WIDTH-1:0]                addr_r,
  output logic [NUM_CH*DATA_WIDTH-1:0]         dout,
  output logic                                 rd_valid,
  output logic                                 transp,
  // bus write port (back bank)
  input  logic                                 we,
  input  logic [NUM_CH-1:0]                    we_mask,
  input  logic [ADDR_WIDTH-1:0]                addr_w,
  input  logic [NUM_CH*DATA_WIDTH-1:0]         din,
  // fill engine
  input  logic                                 fill_start,
  output logic                                 busy,
  output logic                                 fill_done,
  // bank swap
  input  logic                                 swap_req,
  input  logic                                 frame_start,
  output logic                                 swap_pending,
  output logic                                 bank_sel
);

  localparam int PIX_W = NUM_CH * DATA_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  // fill engine state
  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
  logic [PIX_W-1:0]      fill_val_q, fill_val_d;
  logic                  fill_done_q, fill_done_d;

  // swap control
  logic                  swap_pending_q, swap_pending_d;
  logic                  bank_sel_q, bank_sel_d;

  // read pipeline
  logic                  rd_pipe_q, rd_pipe_d;
  logic [PIX_W-1:0]      word_q, word_d;
  logic [PIX_W-1:0]      dout_q, dout_d;
  logic                  rd_valid_q, rd_valid_d;

  // combinational helpers
  logic                  w_busy;
  logic                  w_fill_wr;
  logic                  w_fill_last;
  logic                  w_bus_wr;
  logic                  w_swap_apply;
  logic [NUM_CH-1:0]     w_wr_en;
  logic [PIX_W-1:0]      w_wr_data;
  logic [ADDR_WIDTH:0]   w_wr_idx;
  logic [ADDR_WIDTH:0]   w_rd_idx;
  logic [PIX_W-1:0]      w_rd_word;

  // ------------------------------------------------------------------------
  // Fill FSM: state register plus the fill address/value it walks with
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      fill_addr_q <= '0;
      fill_val_q  <= '0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      fill_val_q  <= fill_val_d;
      fill_done_q <= fill_done_d;
    end
  end

  // Fill FSM next state: IDLE waits for fill_start, FILL walks every address once
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    fill_val_d  = fill_val_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          state_d     = ST_FILL;
          fill_addr_d = '0;
          fill_val_d  = din;
        end
      end
      ST_FILL: begin
        fill_addr_d = fill_addr_q + ADDR_WIDTH'(1);
        if (w_fill_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fill FSM outputs: busy while filling, done pulse follows the last write
  always_comb begin
    w_busy      = (state_q == ST_FILL);
    w_fill_wr   = w_busy;
    w_fill_last = &fill_addr_q;
    fill_done_d = w_busy && w_fill_last;
  end

  // ------------------------------------------------------------------------
  // Swap control: a request waits for a frame tick with the fill engine idle
  always_comb begin
    w_swap_apply   = frame_start && (swap_pending_q || swap_req) && !w_busy;
    bank_sel_d     = w_swap_apply ? ~bank_sel_q : bank_sel_q;
    swap_pending_d = w_swap_apply ? 1'b0 : (swap_pending_q || swap_req);
  end

  // Swap control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      swap_pending_q <= 1'b0;
      bank_sel_q     <= 1'b0;
    end else begin
      swap_pending_q <= swap_pending_d;
      bank_sel_q     <= bank_sel_d;
    end
  end

  // ------------------------------------------------------------------------
  // Write port mux: fill engine owns the port while busy, otherwise the bus.
  // The back bank is always the one not currently selected for display.
  always_comb begin
    w_bus_wr  = we && !w_busy;
    w_wr_en   = w_fill_wr ? {NUM_CH{1'b1}} : (w_bus_wr ? we_mask : '0);
    w_wr_data = w_fill_wr ? fill_val_q : din;
    w_wr_idx  = {~bank_sel_q, (w_fill_wr ? fill_addr_q : addr_w)};
    // Reads issued on the swap edge already see the new front bank
    w_rd_idx  = {bank_sel_d, addr_r};
  end

  // One RAM per colour channel so the write mask is a plain per-RAM enable
  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DATA_WIDTH-1:0] mem [0:2*DEPTH-1];

      // Channel RAM write; contents are intentionally not reset
      always_ff @(posedge clk) begin
        if (w_wr_en[c]) begin
          mem[w_wr_idx] <= w_wr_data[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      assign w_rd_word[c*DATA_WIDTH +: DATA_WIDTH] = mem[w_rd_idx];
    end
  endgenerate

  // ------------------------------------------------------------------------
  // Read pipeline next state: stage 1 captures the RAM word, stage 2 presents it
  always_comb begin
    rd_pipe_d  = rd_en;
    word_d     = rd_en ? w_rd_word : word_q;
    rd_valid_d = rd_pipe_q;
`ifdef SPRITE_PALETTE_TRANSP_EN
    dout_d     = dout_q;
    if (rd_pipe_q) begin
      dout_d = (word_q == KEY_COLOR) ? '0 : word_q;
    end
`else
    dout_d     = rd_pipe_q ? word_q : dout_q;
`endif
  end

  // Read pipeline registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pipe_q  <= 1'b0;
      word_q     <= '0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_pipe_q  <= rd_pipe_d;
      word_q     <= word_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef SPRITE_PALETTE_TRANSP_EN
  logic transp_q, transp_d;

  // Transparency flag travels with dout and holds between reads
  always_comb begin
    transp_d = rd_pipe_q ? (word_q == KEY_COLOR) : transp_q;
  end

  // Transparency flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      transp_q <= 1'b0;
    end else begin
      transp_q <= transp_d;
    end
  end

  assign transp = transp_q;
`else
  assign transp = 1'b0;
`endif

  assign dout         = dout_q;
  assign rd_valid     = rd_valid_q;
  assign busy         = w_busy;
  assign fill_done    = fill_done_q;
  assign swap_pending = swap_pending_q;
  assign bank_sel     = bank_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_palette_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_palette_ram
// Brief    : Self-checking bench for sprite_palette_ram (ADDR_WIDTH=4,
//            NUM_CH=3, DATA_WIDTH=4, KEY_COLOR=0xF0F). A cycle-level
//            reference model of the two banks, read pipeline, fill engine
//            and swap rules is checked every cycle, plus directed checks.
// Options  : SPRITE_PALETTE_TRANSP_EN selects transparency expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_palette_ram;

  localparam int DW    = 4;
  localparam int NC    = 3;
  localparam int AW    = 4;
  localparam int PW    = NC * DW;
  localparam int DEPTH = 16;
  localparam logic [PW-1:0] KEY = 12'hF0F;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] addr_r = '0;
  logic          we = 1'b0;
  logic [NC-1:0] we_mask = '0;
  logic [AW-1:0] addr_w = '0;
  logic [PW-1:0] din = '0;
  logic          fill_start = 1'b0;
  logic          swap_req = 1'b0;
  logic          frame_start = 1'b0;

  logic [PW-1:0] dout;
  logic          rd_valid;
  logic          transp;
  logic          busy;
  logic          fill_done;
  logic          swap_pending;
  logic          bank_sel;

  sprite_palette_ram #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NC),
    .ADDR_WIDTH (AW),
    .KEY_COLOR  (KEY)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_en        (rd_en),
    .addr_r       (addr_r),
    .dout         (dout),
    .rd_valid     (rd_valid),
    .transp       (transp),
    .we           (we),
    .we_mask      (we_mask),
    .addr_w       (addr_w),
    .din          (din),
    .fill_start   (fill_start),
    .busy         (busy),
    .fill_done    (fill_done),
    .swap_req     (swap_req),
    .frame_start  (frame_start),
    .swap_pending (swap_pending),
    .bank_sel     (bank_sel)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [PW-1:0] m_mem [2][DEPTH];
  bit            m_bank, m_pend, m_busy, m_done;
  bit            m_p1v, m_valid, m_transp;
  logic [PW-1:0] m_p1d, m_dout, m_fval;
  int            m_fcnt;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dout", 32'(dout), 32'(m_dout));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("transp", 32'(transp), 32'(m_transp));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("fill_done", 32'(fill_done), 32'(m_done));
    chk("swap_pending", 32'(swap_pending), 32'(m_pend));
    chk("bank_sel", 32'(bank_sel), 32'(m_bank));
  endtask

  task automatic model_reset();
    m_bank = 0; m_pend = 0; m_busy = 0; m_done = 0;
    m_p1v = 0; m_valid = 0; m_transp = 0;
    m_p1d = '0; m_dout = '0; m_fcnt = 0;
  endtask

  // Advance model by one clock using the inputs currently applied, then
  // let the DUT take the same edge and compare.
  task automatic tick();
    bit apply, rb, wb;
    apply = frame_start && (m_pend || swap_req) && !m_busy;
    rb    = apply ? !m_bank : m_bank;
    wb    = !m_bank;
    // output stage
    m_valid = m_p1v;
    if (m_p1v) begin
`ifdef SPRITE_PALETTE_TRANSP_EN
      m_transp = (m_p1d == KEY);
      m_dout   = m_transp ? '0 : m_p1d;
`else
      m_transp = 0;
      m_dout   = m_p1d;
`endif
    end
    // capture stage reads memory as it stood before this edge
    m_p1v = rd_en;
    if (rd_en) m_p1d = m_mem[rb][addr_r];
    // bus write to back bank
    if (we && !m_busy) begin
      for (int c = 0; c < NC; c++)
        if (we_mask[c]) m_mem[wb][addr_w][c*DW +: DW] = din[c*DW +: DW];
    end
    // fill engine
    m_done = 0;
    if (m_busy) begin
      m_mem[wb][m_fcnt] = m_fval;
      if (m_fcnt == DEPTH - 1) begin
        m_busy = 0;
        m_done = 1;
      end else begin
        m_fcnt++;
      end
    end else if (fill_start) begin
      m_busy = 1;
      m_fcnt = 0;
      m_fval = din;
    end
    // swap
    if (apply) begin
      m_bank = !m_bank;
      m_pend = 0;
    end else begin
      m_pend = m_pend || swap_req;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clr();
    rd_en = 0; we = 0; fill_start = 0; swap_req = 0; frame_start = 0;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [PW-1:0] d, input logic [NC-1:0] m);
    clr();
    we = 1; addr_w = a; din = d; we_mask = m;
    tick();
    clr();
  endtask

  // single read; on return dout/rd_valid show the result
  task automatic do_read(input logic [AW-1:0] a);
    clr();
    rd_en = 1; addr_r = a;
    tick();
    rd_en = 0;
    chk("rd_valid_lat1", 32'(rd_valid), 32'(0));
    tick();
    chk("rd_valid_lat2", 32'(rd_valid), 32'(1));
  endtask

  task automatic do_swap();
    clr();
    swap_req = 1;
    tick();
    swap_req = 0; frame_start = 1;
    tick();
    clr();
  endtask

  task automatic do_fill(input logic [PW-1:0] d);
    clr();
    din = d; fill_start = 1;
    tick();
    fill_start = 0;
    repeat (DEPTH) tick();
    clr();
  endtask

  task automatic async_reset();
    @(negedge clk);
    reset_n = 0;
    #1;
    model_reset();
    check_all();
    chk("reset_bank_sel", 32'(bank_sel), 32'(0));
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    int bcnt, dcnt, guard;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) m_mem[b][i] = '0;
    model_reset();

    // reset state
    #1;
    check_all();
    #20;
    @(negedge clk);
    reset_n = 1;

    // initialise both banks, ending with bank 0 in front
    do_fill('0);
    do_swap();
    chk("init_bank1", 32'(bank_sel), 32'(1));
    do_fill('0);
    do_swap();
    chk("init_bank0", 32'(bank_sel), 32'(0));

    // write to back bank is invisible until swap
    bus_write(4'd5, 12'hABC, 3'b111);
    do_read(4'd5);
    chk("old_front", 32'(dout), 32'h000);
    do_swap();
    chk("swap_bank", 32'(bank_sel), 32'(1));
    chk("swap_pend_clr", 32'(swap_pending), 32'(0));
    do_read(4'd5);
    chk("new_front", 32'(dout), 32'hABC);

    // masked write: only the G channel changes
    bus_write(4'd2, 12'h123, 3'b111);
    bus_write(4'd2, 12'hFFF, 3'b010);
    do_swap();
    do_read(4'd2);
    chk("mask_write", 32'(dout), 32'h1F3);

    // transparency key
    bus_write(4'd7, 12'hF0F, 3'b111);
    bus_write(4'd8, 12'hF0E, 3'b111);
    do_swap();
    do_read(4'd7);
`ifdef SPRITE_PALETTE_TRANSP_EN
    chk("key_dout", 32'(dout), 32'h000);
    chk("key_transp", 32'(transp), 32'(1));
`else
    chk("key_dout", 32'(dout), 32'hF0F);
    chk("key_transp", 32'(transp), 32'(0));
`endif
    do_read(4'd8);
    chk("nonkey_dout", 32'(dout), 32'hF0E);
    chk("nonkey_transp", 32'(transp), 32'(0));

    // fill with deferred swap and dropped bus writes
    clr();
    din = 12'h555; fill_start = 1;
    tick();
    bcnt = busy ? 1 : 0;
    dcnt = 0;
    fill_start = 0; swap_req = 1;
    tick(); if (busy) bcnt++;
    swap_req = 0; we = 1; addr_w = 4'd3; din = 12'hEEE; we_mask = 3'b111;
    tick(); if (busy) bcnt++;
    we = 0; frame_start = 1;
    tick(); if (busy) bcnt++;
    frame_start = 0;
    chk("deferred_pend", 32'(swap_pending), 32'(1));
    guard = 0;
    while (busy && guard < 40) begin
      tick();
      if (busy) bcnt++;
      if (fill_done) dcnt++;
      guard++;
    end
    tick();
    if (fill_done) dcnt++;
    chk("fill_busy_cycles", 32'(bcnt), 32'(16));
    chk("fill_done_pulses", 32'(dcnt), 32'(1));
    chk("still_pend", 32'(swap_pending), 32'(1));
    frame_start = 1;
    tick();
    frame_start = 0;
    chk("late_swap_pend", 32'(swap_pending), 32'(0));
    for (int i = 0; i <= DEPTH; i++) begin
      rd_en = (i < DEPTH);
      addr_r = AW'(i);
      tick();
      if (i >= 1) chk("fill_read", 32'(dout), 32'h555);
    end
    clr();

    // reset mid-fill, then a fresh fill completes
    din = 12'h777; fill_start = 1;
    tick();
    fill_start = 0;
    repeat (7) tick();
    async_reset();
    chk("reset_busy", 32'(busy), 32'(0));
    din = 12'h321; fill_start = 1;
    tick();
    fill_start = 0;
    bcnt = busy ? 1 : 0;
    guard = 0;
    while (busy && guard < 40) begin
      tick();
      if (busy) bcnt++;
      guard++;
    end
    chk("refill_cycles", 32'(bcnt), 32'(16));

    // randomized traffic against the model
    repeat (500) begin
      rd_en       = ($urandom_range(0, 1) == 1);
      addr_r      = AW'($urandom_range(0, DEPTH - 1));
      we          = ($urandom_range(0, 3) == 0);
      addr_w      = AW'($urandom_range(0, DEPTH - 1));
      we_mask     = NC'($urandom_range(0, 7));
      din         = ($urandom_range(0, 3) == 0) ? KEY : PW'($urandom_range(0, 4095));
      fill_start  = ($urandom_range(0, 39) == 0);
      swap_req    = ($urandom_range(0, 7) == 0);
      frame_start = ($urandom_range(0, 5) == 0);
      tick();
    end
    clr();

    // async reset in the middle of random traffic
    async_reset();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_palette_ram.md
Name: sprite_palette_ram

Overview:
- Parametrised successor to the per-colour sprite LUTs: one block holds all colour channels of a sprite bitmap in two banks (front/back).
- Pixel pipeline reads the front bank.
- Bus writes and a built-in fill engine target the back bank.
- Banks swap only on a frame boundary, giving tear-free sprite updates; sits between the sprite address generator and the pixel mux.

Parameters:
- DATA_WIDTH, 4, bits per colour channel
- NUM_CH, 3, number of colour channels (R,G,B order, ch0 = LSBs)
- ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH per bank
- KEY_COLOR, 0, NUM_CH*DATA_WIDTH-bit transparency key

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rd_en  in  1  pixel read request
- addr_r  in  ADDR_WIDTH  pixel read address (front bank)
- dout  out  NUM_CH*DATA_WIDTH  pixel colour, packed channels
- rd_valid  out  1  dout valid
- transp  out  1  dout equals KEY_COLOR (see Optional Feature)
- we  in  1  bus write strobe
- we_mask  in  NUM_CH  per-channel write enable
- addr_w  in  ADDR_WIDTH  bus write address (back bank)
- din  in  NUM_CH*DATA_WIDTH  write data, also fill value
- fill_start  in  1  pulse: fill whole back bank with din
- busy  out  1  fill engine active
- fill_done  out  1  one-cycle pulse at fill completion
- swap_req  in  1  pulse: request bank swap
- frame_start  in  1  one-cycle frame-boundary tick
- swap_pending  out  1  swap requested, not yet applied
- bank_sel  out  1  current front bank index

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low: reset_n.
- Reset values:
  - dout = 0, rd_valid = 0, transp = 0
  - busy = 0, fill_done = 0
  - swap_pending = 0, bank_sel = 0
  - Fill FSM in IDLE.
  - RAM contents are not reset.
- Read path, 2-cycle latency:
  - rd_en at edge N registers RAM word front[addr_r].
  - dout, transp and rd_valid update at edge N+1.
  - rd_valid = rd_en delayed 2; dout holds its last value when rd_valid = 0.
  - Back-to-back reads: full throughput.
- Bus write:
  - Write is accepted at the edge where we=1 and busy=0.
  - Target: back bank (~bank_sel as registered before that edge).
  - For each channel c: channel c updated only if we_mask[c] = 1.
  - Writes while busy=1 are dropped silently.
- Fill FSM (IDLE -> FILL -> IDLE):
  - IDLE: fill_start=1 captures din into fill_val, clears fill_addr to 0, enters FILL, busy=1 from next cycle.
  - FILL: each cycle writes fill_val to all channels of back[fill_addr], then fill_addr+1.
  - Exit: the cycle writing address 2**ADDR_WIDTH-1 returns to IDLE; busy=0 and fill_done=1 for exactly one cycle.
  - Fill takes exactly 2**ADDR_WIDTH cycles.
  - fill_start while busy: ignored.
  - fill_start and we in the same IDLE cycle: the write is performed, and the fill starts and later overwrites it.
- Swap:
  - swap_req sets swap_pending.
  - Swap applies at an edge where frame_start=1, pending (or swap_req this cycle) is set, and busy=0: bank_sel toggles, swap_pending clears.
  - swap_req and frame_start in the same cycle: applied immediately.
  - frame_start while busy=1: swap stays pending until the next frame_start after the fill completes.
  - Repeated swap_req while pending: no extra effect.
- Bank-change timing: reads issued at or after the swap edge use the new front bank. A read in flight at the swap completes with the old bank's data.
- Reset mid-fill: FSM returns to IDLE, busy=0. Back bank is left partially filled, which is acceptable.

Optional Feature:
- Macro: SPRITE_PALETTE_TRANSP_EN
- Defined:
  - transp = (RAM word == KEY_COLOR), registered with dout, same 2-cycle latency.
  - When transp=1, dout is forced to 0.
- Undefined:
  - transp tied 0.
  - dout is always the raw RAM word.
  - No comparator is synthesised.

Test Plan:
- Reset check: assert reset_n=0 mid-run -> all outputs 0 immediately (asynchronous), bank_sel=0.
- Write/swap (ADDR_WIDTH=4, NUM_CH=3, DATA_WIDTH=4):
  - Write din=0xABC to addr 5, mask 111 -> read addr 5 still returns old front data.
  - swap_req, then frame_start -> bank_sel=1, swap_pending=0.
  - Read addr 5 -> dout=0xABC, rd_valid exactly 2 cycles after rd_en.
- Mask write: write 0xFFF to addr 2 mask 010 over existing 0x123 -> after swap, read gives 0x1F3.
- Fill with deferred swap: fill_start with din=0x555, swap_req, frame_start at fill cycle 3:
  - busy=1 for 16 cycles, single fill_done pulse.
  - Swap deferred; swap_pending=1 until the next frame_start, then bank_sel toggles.
  - Reads at addr 0..15 return 0x555.
  - Bus writes issued during the fill are dropped.
- Transparency (SPRITE_PALETTE_TRANSP_EN defined, KEY_COLOR=0xF0F): word 0xF0F -> transp=1, dout=0. Word 0xF0E -> transp=0, dout=0xF0E.
- Reset mid-fill: reset_n low at fill cycle 7 -> busy=0 asynchronously. After release, new fill_start is accepted and completes in 16 cycles.
